// File: rtl/param_seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, Run/Busy/Ready handshake.
// Define SIGNED_MULT_EN to enable radix-2 Booth signed operation via Signed_mode.
module param_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Signed_mode,
  input  logic [WIDTH-1:0]     Multiplicand,
  input  logic [WIDTH-1:0]     Multiplier,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Ready
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     acc_nx_c;
  logic [WIDTH-1:0]   q_nx_c;
  logic               fill_c;

`ifdef SIGNED_MULT_EN
  logic               signed_q, signed_d;
  logic               q_prev_q, q_prev_d;
`else
  logic               unused_signed_mode;
  assign unused_signed_mode = Signed_mode;
`endif

  assign Product = product_q;
  assign Busy    = busy_q;
  assign Ready   = ready_q;

  // One add/subtract-then-shift step on {acc,q}
  always_comb begin
    sum_c  = acc_q;
    fill_c = 1'b0;
`ifdef SIGNED_MULT_EN
    if (signed_q) begin
      case ({q_q[0], q_prev_q})
        2'b01:   sum_c = acc_q + {a_q[WIDTH-1], a_q};
        2'b10:   sum_c = acc_q - {a_q[WIDTH-1], a_q};
        default: sum_c = acc_q;
      endcase
      fill_c = sum_c[WIDTH];
    end else if (q_q[0]) begin
      sum_c = acc_q + {1'b0, a_q};
    end
`else
    if (q_q[0]) begin
      sum_c = acc_q + {1'b0, a_q};
    end
`endif
    acc_nx_c = {fill_c, sum_c[WIDTH:1]};
    q_nx_c   = {sum_c[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
`ifdef SIGNED_MULT_EN
    signed_d  = signed_q;
    q_prev_d  = q_prev_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Run) begin
          a_d      = Multiplicand;
          q_d      = Multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          state_d  = CALC;
`ifdef SIGNED_MULT_EN
          signed_d = Signed_mode;
          q_prev_d = 1'b0;
`endif
        end
      end
      CALC: begin
        acc_d = acc_nx_c;
        q_d   = q_nx_c;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SIGNED_MULT_EN
        q_prev_d = q_q[0];
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = {acc_nx_c[WIDTH-1:0], q_nx_c};
          busy_d    = 1'b0;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef SIGNED_MULT_EN
      signed_q  <= 1'b0;
      q_prev_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef SIGNED_MULT_EN
      signed_q  <= signed_d;
      q_prev_q  <= q_prev_d;
`endif
    end
  end

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Self-checking bench for param_seq_multiplier: WIDTH=32 and WIDTH=8 instances vs arithmetic model.
module tb_param_seq_multiplier;

`ifdef SIGNED_MULT_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        run32, sm32;
  logic [31:0] mc32, mp32;
  logic [63:0] prod32;
  logic        busy32, ready32;
  logic        run8, sm8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;
  logic        busy8, ready8;

  int passed = 0;
  int total  = 0;

  param_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .Reset(rst), .Run(run32), .Signed_mode(sm32),
    .Multiplicand(mc32), .Multiplier(mp32),
    .Product(prod32), .Busy(busy32), .Ready(ready32)
  );

  param_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .Reset(rst), .Run(run8), .Signed_mode(sm8),
    .Multiplicand(mc8), .Multiplier(mp8),
    .Product(prod8), .Busy(busy8), .Ready(ready8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ref32 = {32'h0, a} * {32'h0, b};
    if (s && SIGNED_EN) ref32 = sa * sb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    ref8 = {8'h0, a} * {8'h0, b};
    if (s && SIGNED_EN) ref8 = sa * sb;
  endfunction

  // Presents operands for one edge; returns at the negedge after the accepting edge
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    run32 = 1'b1; mc32 = a; mp32 = b; sm32 = s;
    @(negedge clk);
    run32 = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    run8 = 1'b1; mc8 = a; mp8 = b; sm8 = s;
    @(negedge clk);
    run8 = 1'b0;
  endtask

  task automatic wait32(input int from, output int edges);
    edges = from;
    while (!ready32 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait8(output int edges);
    edges = 0;
    while (!ready8 && edges < 50) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    run32 = 1'b0; sm32 = 1'b0; mc32 = '0; mp32 = '0;
    run8 = 1'b0; sm8 = 1'b0; mc8 = '0; mp8 = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({prod32, busy32, ready32} !== 66'h0) $display("FAIL reset32 got p=%h b=%b r=%b want 0", prod32, busy32, ready32);
    else passed++;
    total++;
    if ({prod8, busy8, ready8} !== 18'h0) $display("FAIL reset8 got p=%h b=%b r=%b want 0", prod8, busy8, ready8);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic run_check32(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
    int e;
    logic [63:0] exp;
    exp = ref32(a, b, s);
    start32(a, b, s);
    total++;
    if (busy32 !== 1'b1 || ready32 !== 1'b0) $display("FAIL %s_accept busy=%b ready=%b want 1/0", name, busy32, ready32);
    else passed++;
    wait32(0, e);
    total++;
    if (e !== 32) $display("FAIL %s_latency got %0d want 32", name, e);
    else passed++;
    total++;
    if (prod32 !== exp || busy32 !== 1'b0) $display("FAIL %s_product got %h busy=%b want %h busy=0", name, prod32, busy32, exp);
    else passed++;
  endtask

  task automatic test_unsigned;
    run_check32("u_3x5", 32'd3, 32'd5, 1'b0);
    total++;
    if (prod32 !== 64'h0000_0000_0000_000F) $display("FAIL u_3x5_const got %h want f", prod32);
    else passed++;
    run_check32("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    total++;
    if (prod32 !== 64'hFFFF_FFFE_0000_0001) $display("FAIL u_max_const got %h want fffffffe00000001", prod32);
    else passed++;
    run_check32("u_zero", 32'd0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 4; i++) run_check32("u_rand", $urandom, $urandom, 1'b0);
  endtask

  task automatic test_signed;
    run_check32("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_check32("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    total++;
    if (prod32 !== 64'h4000_0000_0000_0000) $display("FAIL s_minmin_const got %h want 4000000000000000", prod32);
    else passed++;
    run_check32("s_minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 4; i++) run_check32("s_rand", $urandom, $urandom, 1'b1);
  endtask

  task automatic test_back_to_back;
    int e;
    start32(32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    run32 = 1'b1; mc32 = 32'd7; mp32 = 32'd7;
    @(negedge clk);
    run32 = 1'b0;
    wait32(10, e);
    total++;
    if (e !== 32 || prod32 !== 64'd15) $display("FAIL ignore_run got edges=%0d p=%h want 32/f", e, prod32);
    else passed++;
    start32(32'd7, 32'd7, 1'b0);
    total++;
    if (ready32 !== 1'b0 || busy32 !== 1'b1 || prod32 !== 64'd15)
      $display("FAIL b2b_accept got r=%b b=%b p=%h want 0/1/f", ready32, busy32, prod32);
    else passed++;
    wait32(0, e);
    total++;
    if (e !== 32 || prod32 !== 64'd49) $display("FAIL b2b_result got edges=%0d p=%h want 32/31", e, prod32);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (ready32 !== 1'b1 || prod32 !== 64'd49) $display("FAIL ready_hold got r=%b p=%h want 1/31", ready32, prod32);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit saw;
    start32(32'd1234, 32'd5678, 1'b0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (prod32 !== 64'h0 || busy32 !== 1'b0 || ready32 !== 1'b0)
      $display("FAIL reset_mid got p=%h b=%b r=%b want 0/0/0", prod32, busy32, ready32);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready32 || busy32) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) $display("FAIL reset_no_late_ready got activity=1 want 0");
    else passed++;
  endtask

  task automatic test_w8;
    int e;
    logic [7:0] a, b;
    logic s;
    start8(8'h80, 8'h7F, 1'b1);
    wait8(e);
    total++;
    if (e !== 8 || prod8 !== ref8(8'h80, 8'h7F, 1'b1))
      $display("FAIL w8_80x7f got edges=%0d p=%h want 8/%h", e, prod8, ref8(8'h80, 8'h7F, 1'b1));
    else passed++;
    if (SIGNED_EN) begin
      total++;
      if (prod8 !== 16'hC080) $display("FAIL w8_const got %h want c080", prod8);
      else passed++;
    end
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      start8(a, b, s);
      wait8(e);
      total++;
      if (e !== 8 || prod8 !== ref8(a, b, s))
        $display("FAIL w8_rand a=%h b=%h s=%b got edges=%0d p=%h want 8/%h", a, b, s, e, prod8, ref8(a, b, s));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
